mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 8 +
 rtl/arb_watchdog.sv | 18 +
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM/owner types and owner-to-one-hot helper for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic {ARB_FETCH = 1'b0, ARB_DATA = 1'b1} arb_owner_e;
  function automatic logic [1:0] owner_onehot(arb_owner_e o);
    return (o == ARB_DATA) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: 8-bit WAIT-cycle timer; clear_i zeroes, en_i counts, expired_o flags the last allowed cycle
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] count_q, count_d;
  always_comb count_d = clear_i ? 8'd0 : en_i ? count_q + 8'd1 : count_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) count_q <= 8'd0;
    else count_q <= count_d;
  // High in the WAIT cycle whose closing edge would bring the count to TIMEOUT_CYCLES
  assign expired_o = count_q == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter driving a single memory unit with timeout
// Ports: req_i/we_i/addr_*_i/wdata_*_i requester side (bit 0 fetch, bit 1 data);
// grant_o/done_o/err_o/rdata_o/busy_o back to requesters; mem_* command/response toward memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_i,
  input  logic [1:0]                we_i,
  input  logic [ADDRESS_WIDTH-1:0]  addr_0_i,
  input  logic [ADDRESS_WIDTH-1:0]  addr_1_i,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_0_i,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_1_i,
  output logic [1:0]                grant_o,
  output logic [1:0]                done_o,
  output logic [1:0]                err_o,
  output logic [DATA_BUS_WIDTH-1:0] rdata_o,
  output logic                      busy_o,
  output logic                      mem_start_o,
  output logic                      mem_we_o,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata_o,
  input  logic                      mem_done_i,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata_i
);
  arb_state_e                state_q, state_d;
  arb_owner_e                owner_q, owner_d, last_q, last_d;
  logic                      err_q, err_d, mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic                      pick, wd_clr, wd_en, expired;
  // Lone request wins; contention goes to whoever did not own the previous transaction
  assign pick = &req_i ? ~last_q : req_i[1];
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(wd_clr), .en_i(wd_en), .expired_o(expired)
  );
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        owner_d     = arb_owner_e'(pick);
        mem_we_d    = we_i[pick];
        mem_addr_d  = pick ? addr_1_i : addr_0_i;
        mem_wdata_d = pick ? wdata_1_i : wdata_0_i;
        wd_clr      = 1'b1;
        state_d     = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (mem_done_i) begin
        err_d   = 1'b0;
        rdata_d = mem_we_q ? rdata_q : mem_rdata_i;
        state_d = RESP;
      end else if (expired) begin
        err_d   = 1'b1;
        state_d = RESP;
      end else wd_en = 1'b1;
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= ARB_FETCH;
      last_q      <= ARB_DATA;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  assign busy_o      = state_q != IDLE;
  assign mem_start_o = state_q == ISSUE;
  assign grant_o     = busy_o ? owner_onehot(owner_q) : 2'b00;
  assign done_o      = (state_q == RESP && !err_q) ? owner_onehot(owner_q) : 2'b00;
  assign err_o       = (state_q == RESP && err_q) ? owner_onehot(owner_q) : 2'b00;
  assign rdata_o     = rdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven scoreboard bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;
  localparam int T = 5;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  req_i = '0, we_i = '0;
  logic [15:0] addr_0_i = '0, addr_1_i = '0;
  logic [7:0]  wdata_0_i = '0, wdata_1_i = '0;
  logic [1:0]  grant_o, done_o, err_o;
  logic [7:0]  rdata_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o, mem_start_o, mem_we_o, mem_done_i;
  logic [15:0] mem_addr_o;

  mem_arbiter #(.DATA_BUS_WIDTH(8), .ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_0_i(addr_0_i), .addr_1_i(addr_1_i), .wdata_0_i(wdata_0_i), .wdata_1_i(wdata_1_i),
    .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_start_o(mem_start_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req, we; logic [15:0] a0, a1; logic [7:0] w0, w1, md; int lat;
    logic [1:0] g; logic mwe; logic [15:0] ma; logic [7:0] mw;
    logic [1:0] dn, er; logic [7:0] rd; int dly;
  } vec_t;
  typedef struct { logic [1:0] g; logic we; logic [15:0] a; logic [7:0] w; } cmd_t;
  typedef struct { logic [1:0] dn, er; logic [7:0] rd; int dly; } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  vec_t tbl[8];
  int n_vec = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  int resp_lat = 0, cnt = 0;
  logic [7:0] resp_data = '0, stray_data = '0;
  logic stray = 1'b0, fire;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: answers resp_lat cycles after a start (0 = never), plus optional stray pulses
  always @(negedge clk) begin
    fire = 1'b0;
    if (mem_start_o) cnt = resp_lat;
    else if (cnt > 0) begin
      cnt--;
      fire = (cnt == 0);
    end
    mem_done_i  = fire | stray;
    mem_rdata_i = fire ? resp_data : stray_data;
  end

  // Scoreboard: commands checked at mem_start, responses checked at done/err
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    cyc++;
    if ($countones(grant_o) > 1 || $countones(done_o) > 1 || $countones(err_o) > 1) begin
      n_fail++;
      $display("FAIL onehot: grant %b done %b err %b", grant_o, done_o, err_o);
    end
    if (mem_start_o) begin
      start_cyc = cyc;
      if (cmd_q.size() == 0) chk("unexpected_start", 64'(mem_start_o), 64'd0);
      else begin
        c = cmd_q.pop_front();
        chk("cmd", {grant_o, mem_we_o, mem_addr_o, mem_wdata_o}, {c.g, c.we, c.a, c.w});
      end
    end
    if (|done_o || |err_o) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", {done_o, err_o}, 64'd0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp", {done_o, err_o, rdata_o, 32'(cyc - start_cyc)}, {r.dn, r.er, r.rd, 32'(r.dly)});
      end
    end
  end

  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      ok = mem_start_o;
    end
    if (!ok) chk("start_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !busy_o;
    end
    if (!ok) chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic run(input vec_t v, input bit chg);
    cmd_q.push_back('{v.g, v.mwe, v.ma, v.mw});
    rsp_q.push_back('{v.dn, v.er, v.rd, v.dly});
    resp_lat = v.lat; resp_data = v.md;
    req_i = v.req; we_i = v.we; addr_0_i = v.a0; addr_1_i = v.a1; wdata_0_i = v.w0; wdata_1_i = v.w1;
    wait_start();
    req_i = 2'b00;
    if (chg) begin
      addr_0_i = ~v.a0; addr_1_i = ~v.a1; we_i = ~v.we; wdata_0_i = ~v.w0; wdata_1_i = ~v.w1;
      @(negedge clk);
      chk("held_cmd", {mem_we_o, mem_addr_o, mem_wdata_o}, {v.mwe, v.ma, v.mw});
    end
    wait_idle();
  endtask

  initial begin
    int k;
    tbl[0] = '{2'b01, 2'b00, 16'h1234, 16'h0000, 8'h00, 8'h00, 8'hA5, 2, 2'b01, 1'b0, 16'h1234, 8'h00, 2'b01, 2'b00, 8'hA5, 3};
    tbl[1] = '{2'b10, 2'b10, 16'h0000, 16'hBEEF, 8'h00, 8'h5A, 8'h00, 1, 2'b10, 1'b1, 16'hBEEF, 8'h5A, 2'b10, 2'b00, 8'hA5, 2};
    tbl[2] = '{2'b10, 2'b10, 16'h0000, 16'h0BAD, 8'h00, 8'h3C, 8'h00, 0, 2'b10, 1'b1, 16'h0BAD, 8'h3C, 2'b00, 2'b10, 8'hA5, T + 1};
    tbl[3] = '{2'b01, 2'b00, 16'h0001, 16'h0000, 8'h11, 8'h00, 8'h77, T, 2'b01, 1'b0, 16'h0001, 8'h11, 2'b01, 2'b00, 8'h77, T + 1};
    tbl[4] = '{2'b01, 2'b00, 16'h0002, 16'h0000, 8'h00, 8'h00, 8'h88, T + 1, 2'b01, 1'b0, 16'h0002, 8'h00, 2'b00, 2'b01, 8'h77, T + 1};
    tbl[5] = '{2'b11, 2'b11, 16'h1111, 16'h2222, 8'hAA, 8'hBB, 8'h00, 3, 2'b10, 1'b1, 16'h2222, 8'hBB, 2'b10, 2'b00, 8'h77, 4};
    tbl[6] = '{2'b11, 2'b00, 16'h3333, 16'h4444, 8'hCC, 8'hDD, 8'hC3, 1, 2'b01, 1'b0, 16'h3333, 8'hCC, 2'b01, 2'b00, 8'hC3, 2};
    tbl[7] = '{2'b10, 2'b00, 16'h5555, 16'h6666, 8'h01, 8'h02, 8'h19, 4, 2'b10, 1'b0, 16'h6666, 8'h02, 2'b10, 2'b00, 8'h19, 5};
    @(negedge clk);
    chk("reset_state", {grant_o, done_o, err_o, rdata_o, busy_o, mem_start_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run(tbl[i], 1'b0);
    // Requester drops req and scrambles its command right after the grant
    run('{2'b01, 2'b00, 16'h4444, 16'h0000, 8'h21, 8'h00, 8'h66, 2, 2'b01, 1'b0, 16'h4444, 8'h21, 2'b01, 2'b00, 8'h66, 3}, 1'b1);
    // Stray mem_done while idle must leave rdata alone
    @(negedge clk); #1 stray_data = 8'hEE; stray = 1'b1;
    @(negedge clk); #1 stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_done", {busy_o, rdata_o}, {1'b0, 8'h66});
    // Fresh reset, then both requesters held high: strict alternation starting at requester 0
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back(i % 2 ? '{2'b10, 1'b0, 16'h0B0B, 8'h02} : '{2'b01, 1'b0, 16'h0A0A, 8'h01});
      rsp_q.push_back('{i % 2 ? 2'b10 : 2'b01, 2'b00, 8'h11, 2});
    end
    resp_lat = 1; resp_data = 8'h11;
    req_i = 2'b11; we_i = 2'b00; addr_0_i = 16'h0A0A; addr_1_i = 16'h0B0B; wdata_0_i = 8'h01; wdata_1_i = 8'h02;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge clk);
      if (|done_o || |err_o) k++;
    end
    req_i = 2'b00;
    if (k != 4) chk("rr_timeout", 64'(k), 64'd4);
    wait_idle();
    // Leave last owner = 0, start a data access, reset it mid-WAIT
    run('{2'b01, 2'b00, 16'h0100, 16'h0000, 8'h00, 8'h00, 8'h42, 1, 2'b01, 1'b0, 16'h0100, 8'h00, 2'b01, 2'b00, 8'h42, 2}, 1'b0);
    cmd_q.push_back('{2'b10, 1'b0, 16'h0200, 8'h00});
    resp_lat = 0;
    req_i = 2'b10; we_i = 2'b00; addr_1_i = 16'h0200; wdata_1_i = 8'h00;
    wait_start();
    req_i = 2'b00;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1 chk("reset_mid_wait", {grant_o, done_o, err_o, rdata_o, busy_o, mem_start_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    run('{2'b11, 2'b00, 16'h0300, 16'h0400, 8'h07, 8'h08, 8'h5D, 1, 2'b01, 1'b0, 16'h0300, 8'h07, 2'b01, 2'b00, 8'h5D, 2}, 1'b0);
    chk("queues_drained", 64'(cmd_q.size() + rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
